// File: rtl/alu_pkg.sv
// Shared ALU definitions: loader FSM state type, default widths, opcode values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned OPW_DEF     = 4;
    localparam int unsigned TIMEOUT_DEF = 16;

    // ALU opcodes, shared with the datapath
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_B  = 2'd1,
        PRESENT = 2'd2
    } loader_state_t;

    // The unused encoding 2'd3 behaves as IDLE so a corrupted state self-recovers.
    function automatic loader_state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return WAIT_B;
            2'd2:    return PRESENT;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand loader bus: shared operand/opcode input, strobes, and registered operand set.
// Latency: n/a (wiring only).
// Backpressure: readyIn from the ALU side holds the presented set while low.
interface alu_operand_loader_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned OPW = 4
);
    logic [N-1:0]   dataIn;
    logic [OPW-1:0] opIn;
    logic           loadIn;
    logic           clearIn;
    logic           readyIn;
    logic [N-1:0]   aOut;
    logic [N-1:0]   bOut;
    logic [OPW-1:0] opOut;
    logic           validOut;
    logic [1:0]     stateOut;
    logic           timeoutOut;

    // Producer / board side
    modport master (
        output dataIn, opIn, loadIn, clearIn, readyIn,
        input  aOut, bOut, opOut, validOut, stateOut, timeoutOut
    );

    // Loader side
    modport slave (
        input  dataIn, opIn, loadIn, clearIn, readyIn,
        output aOut, bOut, opOut, validOut, stateOut, timeoutOut
    );
endinterface

// File: rtl/alu_operand_loader_timeout_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
// Latency: tc asserts in the cycle the registered count equals TERMINAL.
// Backpressure: none; counts whenever enabled, wraps past all-ones.
module timeout_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear dominates enable
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/alu_operand_loader.sv
// Collects A, then B+opcode, from one shared bus and presents them as a registered set.
// Latency: set valid 1 cycle after the B strobe; all outputs registered.
// Backpressure: holds validOut and operands stable until readyIn; LOADER_TIMEOUT_EN adds WAIT_B abort.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned OPW     = OPW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_loader_if.slave  bus
);
    loader_state_t  state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           valid_q, valid_d;
    logic           timeout_q, timeout_d;
    logic           wait_tc;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TC_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    // Counts cycles spent in WAIT_B; held at zero elsewhere so each entry starts fresh
    timeout_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (TC_LAST)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clearIn || (state_q != WAIT_B)),
        .en    (state_q == WAIT_B),
        .tc    (wait_tc)
    );
`else
    assign wait_tc = 1'b0;
`endif

    // Next-state and operand capture; clear overrides everything, loads ignored in PRESENT
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        timeout_d = 1'b0;
        if (bus.clearIn) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else begin
            case (decode_state(state_q))
                IDLE: begin
                    if (bus.loadIn) begin
                        a_d     = bus.dataIn;
                        b_d     = '0;
                        op_d    = '0;
                        state_d = WAIT_B;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_B: begin
                    if (bus.loadIn) begin
                        b_d     = bus.dataIn;
                        op_d    = bus.opIn;
                        state_d = PRESENT;
                    end else if (wait_tc && (TIMEOUT != 0)) begin
                        // A strobe on the final count cycle takes the branch above instead
                        a_d       = '0;
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
                PRESENT: begin
                    if (bus.readyIn) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = (state_d == PRESENT);
    end

    // State, operand and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.aOut       = a_q;
    assign bus.bOut       = b_q;
    assign bus.opOut      = op_q;
    assign bus.validOut   = valid_q;
    assign bus.stateOut   = state_q;
    assign bus.timeoutOut = timeout_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a per-cycle reference model.
// Latency: n/a.
// Backpressure: exercises readyIn low/high and the WAIT_B abort path.
module tb_alu_operand_loader;
    localparam int unsigned N       = 4;
    localparam int unsigned OPW     = 4;
    localparam int unsigned TIMEOUT = 16;
`ifdef LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    alu_operand_loader_if #(.N(N), .OPW(OPW)) bus ();

    alu_operand_loader #(.N(N), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit cmp_en  = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: stage 0 = nothing held, 1 = A held, 2 = set offered.
    int       m_stage;
    int       m_idle;
    bit [3:0] m_a, m_b, m_op;
    bit       m_valid, m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stage = 0; m_idle = 0;
            m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (bus.clearIn) begin
                m_stage = 0; m_a = 0; m_b = 0; m_op = 0;
            end else if (m_stage == 0) begin
                if (bus.loadIn) begin
                    m_a = bus.dataIn; m_b = 0; m_op = 0;
                    m_stage = 1; m_idle = 0;
                end
            end else if (m_stage == 1) begin
                if (bus.loadIn) begin
                    m_b = bus.dataIn; m_op = bus.opIn; m_stage = 2;
                end else begin
                    m_idle++;
                    if (TO_EN && m_idle == TIMEOUT) begin
                        m_a = 0; m_stage = 0; m_to = 1;
                    end
                end
            end else if (bus.readyIn) begin
                m_stage = 0;
            end
            m_valid = (m_stage == 2);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("aOut",       int'(bus.aOut),       int'(m_a));
            chk("bOut",       int'(bus.bOut),       int'(m_b));
            chk("opOut",      int'(bus.opOut),      int'(m_op));
            chk("validOut",   int'(bus.validOut),   int'(m_valid));
            chk("stateOut",   int'(bus.stateOut),   m_stage);
            chk("timeoutOut", int'(bus.timeoutOut), int'(m_to));
        end
    end

    // Apply inputs for one cycle; returns at the following falling edge
    task automatic cyc(input logic ld, input logic [3:0] d, input logic [3:0] op,
                       input logic clr, input logic rdy);
        bus.loadIn  = ld;
        bus.dataIn  = d;
        bus.opIn    = op;
        bus.clearIn = clr;
        bus.readyIn = rdy;
        @(negedge clk);
    endtask

    task automatic pin(input string nm, input int a, input int b, input int op,
                       input int v, input int st);
        chk({nm, ".a"},  int'(bus.aOut),     a);
        chk({nm, ".b"},  int'(bus.bOut),     b);
        chk({nm, ".op"}, int'(bus.opOut),    op);
        chk({nm, ".v"},  int'(bus.validOut), v);
        chk({nm, ".st"}, int'(bus.stateOut), st);
        chk({nm, ".model_st"}, m_stage, st);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.loadIn = 0; bus.dataIn = 0; bus.opIn = 0; bus.clearIn = 0; bus.readyIn = 0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        pin("reset", 0, 0, 0, 0, 0);
        chk("reset.to", int'(bus.timeoutOut), 0);
        rst_n = 1'b1;

        // Reset mid-WAIT_B discards the held A immediately
        cyc(1, 4'h5, 4'h0, 0, 0);
        pin("loadA5", 5, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 pin("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 4'h0, 4'h0, 0, 0);
        pin("post_rst", 0, 0, 0, 0, 0);

        // Basic transfer with readyIn high: valid for exactly one cycle
        cyc(1, 4'h3, 4'h0, 0, 1);
        pin("A3", 3, 0, 0, 0, 1);
        cyc(1, 4'h7, 4'h2, 0, 1);
        pin("B7", 3, 7, 2, 1, 2);
        chk("model_b", int'(m_b), 7);
        cyc(0, 4'h0, 4'h0, 0, 1);
        pin("xfer", 3, 7, 2, 0, 0);

        // Backpressure: ready low 5 cycles, strobe ignored while presenting
        cyc(1, 4'hA, 4'h0, 0, 0);
        cyc(1, 4'h4, 4'h1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc((i == 2), 4'hF, 4'hE, 0, 0);
            pin("hold", 10, 4, 1, 1, 2);
        end
        cyc(1, 4'hF, 4'hE, 0, 1);
        pin("hold_xfer", 10, 4, 1, 0, 0);

        // Clear beats load in WAIT_B
        cyc(1, 4'h6, 4'h0, 0, 0);
        cyc(1, 4'h9, 4'h3, 1, 0);
        pin("clr_wait", 0, 0, 0, 0, 0);

        // Clear beats ready in PRESENT
        cyc(1, 4'h1, 4'h0, 0, 0);
        cyc(1, 4'h2, 4'h5, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, 1);
        pin("clr_present", 0, 0, 0, 0, 0);

        // Held strobe: two consecutive cycles load A then B
        cyc(1, 4'h8, 4'h4, 0, 0);
        cyc(1, 4'hC, 4'h4, 0, 0);
        pin("held_load", 8, 12, 4, 1, 2);
        cyc(0, 4'h0, 4'h0, 0, 1);

`ifdef LOADER_TIMEOUT_EN
        // No strobe for TIMEOUT cycles aborts WAIT_B with a one-cycle pulse
        cyc(1, 4'h9, 4'h0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 4'h0, 4'h0, 0, 0);
        pin("pre_to", 9, 0, 0, 0, 1);
        cyc(0, 4'h0, 4'h0, 0, 0);
        pin("timeout", 0, 0, 0, 0, 0);
        chk("timeout.pulse", int'(bus.timeoutOut), 1);
        cyc(0, 4'h0, 4'h0, 0, 0);
        chk("timeout.pulse_end", int'(bus.timeoutOut), 0);
        // Strobe on the final count cycle wins
        cyc(1, 4'h9, 4'h0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 4'h0, 4'h0, 0, 0);
        cyc(1, 4'hB, 4'h6, 0, 0);
        pin("late_b", 9, 11, 6, 1, 2);
        chk("late_b.to", int'(bus.timeoutOut), 0);
        cyc(0, 4'h0, 4'h0, 0, 1);
`else
        // Without the abort feature WAIT_B waits indefinitely
        cyc(1, 4'h9, 4'h0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(0, 4'h0, 4'h0, 0, 0);
            chk("wait_forever.st", int'(bus.stateOut), 1);
            chk("wait_forever.to", int'(bus.timeoutOut), 0);
        end
        pin("wait_forever", 9, 0, 0, 0, 1);
        cyc(1, 4'hB, 4'h6, 0, 1);
        pin("late_b", 9, 11, 6, 1, 2);
        cyc(0, 4'h0, 4'h0, 0, 1);
`endif
        pin("final", int'(m_a), int'(m_b), int'(m_op), 0, 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
